mul_mdc_ctrl_fsm: RTL

Control-side counterpart of the mul_mdc engine. It owns the engine's control channel: it drives `ctrl_engine_t` (clear, start, kernel registers) and consumes `flags_engine_t` (ready, done, output count). A job is triggered from the register file; the block sequences engine clear/start and streamer start, waits for engine completion and streamer drain, then reports completion as a one-cycle event.

---
 rtl/mul_mdc_package.sv | 42 ++++
 rtl/mul_mdc_watchdog.sv | 30 +++
 rtl/mul_mdc_ctrl_fsm.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mul_mdc_package.sv
// Shared types and constants for the mul_mdc engine and its control FSM.
package mul_mdc_package;

  // Width of the engine's output-count flag.
  localparam int unsigned MUL_MDC_CNT_WIDTH = 16;

  // Default watchdog limit for the COMPUTE+DRAIN phases, in cycles.
  localparam int unsigned MUL_MDC_TIMEOUT_DEFAULT = 65536;

  // Control channel driven into the engine.
  typedef struct packed {
    logic        start;
    logic        clear;
    logic [31:0] reg_simple_mul;
    logic [31:0] reg_shift;
    logic [31:0] reg_len;
  } ctrl_engine_t;

  // Status channel coming back from the engine.
  typedef struct packed {
    logic                         ready;
    logic                         done;
    logic [MUL_MDC_CNT_WIDTH-1:0] cnt_d;
  } flags_engine_t;

  // Job sequencing states of the control FSM.
  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_CLEAR,
    FSM_WAIT_READY,
    FSM_START,
    FSM_COMPUTE,
    FSM_DRAIN,
    FSM_DONE
  } mul_mdc_fsm_state_t;

  // Counter width able to hold the value 'limit'. A zero limit still needs one bit.
  function automatic int unsigned watchdog_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mul_mdc_watchdog.sv
// Cycle counter that flags expiry once 'limit' enabled cycles have elapsed.
// A zero limit disables expiry entirely.
module mul_mdc_watchdog #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // The current cycle is the limit-th enabled one when count is limit-1.
  assign expire = enable && (limit != '0) && (count == limit - WIDTH'(1));

  // Count enabled cycles, holding at the expiry value until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mul_mdc_ctrl_fsm.sv
// Control-side sequencer of the mul_mdc engine: accepts a job, clears and
// starts the engine and streamer, waits for completion and drain, and
// reports a one-cycle done event with the captured output count.
module mul_mdc_ctrl_fsm
  import mul_mdc_package::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MUL_MDC_TIMEOUT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          test_mode_i,
  input  logic          clear_i,
  input  logic          trigger_i,
  input  logic [31:0]   reg_simple_mul_i,
  input  logic [31:0]   reg_shift_i,
  input  logic [31:0]   reg_len_i,
  output ctrl_engine_t  ctrl_engine_o,
  input  flags_engine_t flags_engine_i,
  output logic          strm_start_o,
  input  logic          strm_done_i,
  output logic          busy_o,
  output logic          evt_done_o,
  output logic          err_o,
  output logic [31:0]   cnt_o
);

  localparam int unsigned WD_WIDTH = watchdog_width(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

  mul_mdc_fsm_state_t state, next_state;

  logic        accept;
  logic        timeout;
  logic        engine_clear;
  logic        done_seen;
  logic        drain_seen;
  logic        err;
  logic [31:0] cnt;
  logic [31:0] reg_simple_mul;
  logic [31:0] reg_shift;
  logic [31:0] reg_len;
  logic        wd_enable;
  logic        wd_clear;
  logic        wd_expire;
  logic        unused_test_mode;

  assign unused_test_mode = test_mode_i;

  assign wd_enable = (state == FSM_COMPUTE) || (state == FSM_DRAIN);
  assign wd_clear  = clear_i || (state == FSM_CLEAR);

  mul_mdc_watchdog #(
    .WIDTH (WD_WIDTH)
  ) i_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .enable (wd_enable),
    .clear  (wd_clear),
    .limit  (WD_LIMIT),
    .expire (wd_expire)
  );

  // Next-state decode; a soft clear overrides every other transition.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      FSM_IDLE: begin
        if (trigger_i) begin
          accept     = 1'b1;
          next_state = (reg_len_i == '0) ? FSM_DONE : FSM_CLEAR;
        end
      end
      FSM_CLEAR:      next_state = FSM_WAIT_READY;
      FSM_WAIT_READY: if (flags_engine_i.ready) next_state = FSM_START;
      FSM_START:      next_state = FSM_COMPUTE;
      FSM_COMPUTE: begin
        if (wd_expire) begin
          timeout    = 1'b1;
          next_state = FSM_DONE;
        end else if (flags_engine_i.done || done_seen) begin
          next_state = FSM_DRAIN;
        end
      end
      FSM_DRAIN: begin
        if (wd_expire) begin
          timeout    = 1'b1;
          next_state = FSM_DONE;
        end else if (drain_seen || strm_done_i) begin
          next_state = FSM_DONE;
        end
      end
      FSM_DONE:       next_state = FSM_IDLE;
      default:        next_state = FSM_IDLE;
    endcase
    if (clear_i) begin
      next_state = FSM_IDLE;
      accept     = 1'b0;
      timeout    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FSM_IDLE;
    else         state <= next_state;
  end

  // Kernel registers stay stable from one accepted trigger to the next.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_simple_mul <= '0;
      reg_shift      <= '0;
      reg_len        <= '0;
    end else if (accept) begin
      reg_simple_mul <= reg_simple_mul_i;
      reg_shift      <= reg_shift_i;
      reg_len        <= reg_len_i;
    end
  end

  // Engine clear is registered: high throughout CLEAR and after a soft clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) engine_clear <= 1'b0;
    else         engine_clear <= clear_i || (next_state == FSM_CLEAR);
  end

  // Remember engine done and streamer drain seen while computing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_seen  <= 1'b0;
      drain_seen <= 1'b0;
    end else if (clear_i || (state == FSM_CLEAR)) begin
      done_seen  <= 1'b0;
      drain_seen <= 1'b0;
    end else if (state == FSM_COMPUTE) begin
      done_seen  <= done_seen  || flags_engine_i.done;
      drain_seen <= drain_seen || strm_done_i;
    end
  end

  // Sticky watchdog error and output count captured on entry to DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
      cnt <= '0;
    end else if (clear_i) begin
      err <= 1'b0;
      cnt <= '0;
    end else begin
      if (timeout) err <= 1'b1;
      if (next_state == FSM_DONE) cnt <= 32'(flags_engine_i.cnt_d);
    end
  end

  // Outputs decoded from registered state and registers only.
  always_comb begin
    ctrl_engine_o                = '0;
    ctrl_engine_o.start          = (state == FSM_START);
    ctrl_engine_o.clear          = engine_clear;
    ctrl_engine_o.reg_simple_mul = reg_simple_mul;
    ctrl_engine_o.reg_shift      = reg_shift;
    ctrl_engine_o.reg_len        = reg_len;
  end

  assign strm_start_o = (state == FSM_START);
  assign busy_o       = (state != FSM_IDLE);
  assign evt_done_o   = (state == FSM_DONE);
  assign err_o        = err;
  assign cnt_o        = cnt;

endmodule
